// File: rtl/data_ram_ws_pkg.sv
// Shared bus widths, signal levels and state encodings for the data-memory responder.
// Imported by data_ram_array and data_ram_ws.
package data_ram_ws_pkg;

    localparam int DATA_ADDR_BUS_W    = 32;
    localparam int DATA_BUS_W         = 32;
    localparam int DATA_MEM_SEL_BUS_W = 4;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'b00,
        RAM_WAIT = 2'b01,
        RAM_DONE = 2'b10
    } ram_state_t;

endpackage

// File: rtl/data_ram_array.sv
// Word storage: asynchronous read and per-byte-lane synchronous write.
// Lane sel[3] drives bits 31:24 (big-endian byte offset 0). No reset on contents.
module data_ram_array
    import data_ram_ws_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [DEPTH_LOG2-1:0]         idx,
    input  logic [DATA_MEM_SEL_BUS_W-1:0] sel,
    input  logic [DATA_BUS_W-1:0]         wdata,
    output logic [DATA_BUS_W-1:0]         rdata
);

    logic [DATA_BUS_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en == WRITE_ENABLE) begin
            for (int lane = 0; lane < DATA_MEM_SEL_BUS_W; lane++) begin
                if (sel[lane]) begin
                    mem[idx][lane*8 +: 8] <= wdata[lane*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_ram_ws.sv
// Data-memory responder for the CPU load/store port with configurable wait states.
// Stalls the pipeline for WAIT_CYCLES cycles per access, then completes in DONE.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RAM_IDLE | ready; ce=1 latches the request, asserts stall, loads cnt
//   RAM_WAIT | request latched; stall held while cnt counts down to 1
//   RAM_DONE | completion: read data driven or write committed, no stall
module data_ram_ws
    import data_ram_ws_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          we,
    input  logic [DATA_ADDR_BUS_W-1:0]    addr,
    input  logic [DATA_MEM_SEL_BUS_W-1:0] sel,
    input  logic [DATA_BUS_W-1:0]         data_i,
    output logic [DATA_BUS_W-1:0]         data_o,
    output logic                          stallreq_o
);

    logic [DEPTH_LOG2-1:0]         req_idx;
    logic [DEPTH_LOG2-1:0]         arr_idx;
    logic                          arr_we;
    logic [DATA_MEM_SEL_BUS_W-1:0] arr_sel;
    logic [DATA_BUS_W-1:0]         arr_wdata;
    logic [DATA_BUS_W-1:0]         arr_rdata;
    logic                          unused_addr_bits;

    // Byte offset and bits above the RAM depth are don't-care; addresses alias.
    assign req_idx          = addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{addr[DATA_ADDR_BUS_W-1:DEPTH_LOG2+2], addr[1:0]};

    data_ram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_we),
        .idx   (arr_idx),
        .sel   (arr_sel),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    generate
        if (WAIT_CYCLES == 0) begin : g_zero_wait
            always_comb begin
                arr_idx    = req_idx;
                arr_sel    = sel;
                arr_wdata  = data_i;
                arr_we     = WRITE_DISABLE;
                data_o     = ZERO_WORD;
                stallreq_o = NO_STOP;
                if (!rst && ce == CHIP_ENABLE) begin
                    if (we == WRITE_ENABLE) begin
                        arr_we = WRITE_ENABLE;
                    end else begin
                        data_o = arr_rdata;
                    end
                end
            end
        end else begin : g_fsm
            localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
            localparam ram_state_t       ACCEPT_NXT = (WAIT_CYCLES == 1) ? RAM_DONE : RAM_WAIT;

            ram_state_t                    state;
            ram_state_t                    state_nxt;
            logic [CNT_W-1:0]              cnt;
            logic                          accept;
            logic                          lat_we;
            logic [DEPTH_LOG2-1:0]         lat_idx;
            logic [DATA_MEM_SEL_BUS_W-1:0] lat_sel;
            logic [DATA_BUS_W-1:0]         lat_data;

            always_comb begin
                state_nxt  = state;
                accept     = 1'b0;
                stallreq_o = NO_STOP;
                data_o     = ZERO_WORD;
                arr_we     = WRITE_DISABLE;
                arr_idx    = lat_idx;
                arr_sel    = lat_sel;
                arr_wdata  = lat_data;
                case (state)
                    RAM_IDLE: begin
                        if (ce == CHIP_ENABLE) begin
                            accept     = 1'b1;
                            stallreq_o = STOP;
                            state_nxt  = ACCEPT_NXT;
                        end
                    end
                    RAM_WAIT: begin
                        stallreq_o = STOP;
                        if (cnt == CNT_W'(1)) begin
                            state_nxt = RAM_DONE;
                        end
                    end
                    RAM_DONE: begin
                        state_nxt = RAM_IDLE;
                        if (lat_we == WRITE_ENABLE) begin
                            arr_we = WRITE_ENABLE;
                        end else begin
                            data_o = arr_rdata;
                        end
                    end
                    default: state_nxt = RAM_IDLE;
                endcase
                // Reset wins immediately: no stall, no data, and a pending write is dropped.
                if (rst) begin
                    accept     = 1'b0;
                    stallreq_o = NO_STOP;
                    data_o     = ZERO_WORD;
                    arr_we     = WRITE_DISABLE;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= RAM_IDLE;
                    cnt      <= '0;
                    lat_we   <= WRITE_DISABLE;
                    lat_idx  <= '0;
                    lat_sel  <= '0;
                    lat_data <= ZERO_WORD;
                end else begin
                    state <= state_nxt;
                    if (accept) begin
                        lat_we   <= we;
                        lat_idx  <= req_idx;
                        lat_sel  <= sel;
                        lat_data <= data_i;
                        cnt      <= CNT_LOAD;
                    end else if (state == RAM_WAIT) begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule
